// File: rtl/channel_pkg.sv
// channel_pkg: shared channel constants and latency arithmetic
package channel_pkg;

    localparam int N_DEFAULT             = 10;
    localparam int LATENCY_WIDTH_DEFAULT = 6;

    // Adds two latency values and clamps the sum at the largest w-bit value.
    // The 32-bit sum is wide enough that it cannot overflow for any legal field width.
    function automatic int unsigned lat_sat(input int unsigned a, input int unsigned b,
                                            input int unsigned w);
        int unsigned max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (a + b > max_v) ? max_v : a + b;
    endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// channel_fifo_mem: DEPTH x N storage, one write port, asynchronous read port
module channel_fifo_mem
    import channel_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// channel_fifo: elastic valid/ready buffer that also reports upstream latency
module channel_fifo
    import channel_pkg::*;
#(
    parameter int N                   = N_DEFAULT,
    parameter int LATENCY_COUNT_WIDTH = LATENCY_WIDTH_DEFAULT,
    parameter int DEPTH               = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [N-1:0]                   in_data,
    output logic                           in_ready,
    output logic [LATENCY_COUNT_WIDTH-1:0] in_latency,
    output logic                           out_valid,
    output logic [N-1:0]                   out_data,
    input  logic                           out_ready,
    input  logic [LATENCY_COUNT_WIDTH-1:0] out_latency
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop;

    // Flags come from the registered count only, so ready never depends on out_ready.
    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's transfers; a simultaneous push and pop cancel.
    always_comb begin
        count_next = (push && !pop) ? count + 1'b1 :
                     (pop && !push) ? count - 1'b1 : count;
    end

    // Pointer, occupancy and latency registers; reset empties the stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_latency <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count      <= count_next;
            in_latency <= LATENCY_COUNT_WIDTH'(lat_sat(32'(count_next), 32'(out_latency),
                                                       LATENCY_COUNT_WIDTH));
        end
    end

    channel_fifo_mem #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_channel_fifo.sv
// tb_channel_fifo: directed vectors, corner sequences and a scoreboard soak
module tb_channel_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv, ir, ov, orr;
    logic [9:0] id, od;
    logic [5:0] il, ol;
    logic       iv3, ir3, ov3, or3;
    logic [9:0] id3, od3;
    logic [5:0] il3, ol3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_fifo #(.N(10), .LATENCY_COUNT_WIDTH(6), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_data(id), .in_ready(ir), .in_latency(il),
        .out_valid(ov), .out_data(od), .out_ready(orr), .out_latency(ol)
    );

    channel_fifo #(.N(10), .LATENCY_COUNT_WIDTH(6), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv3), .in_data(id3), .in_ready(ir3), .in_latency(il3),
        .out_valid(ov3), .out_data(od3), .out_ready(or3), .out_latency(ol3)
    );

    typedef struct {
        logic       iv;
        logic [9:0] id;
        logic       orr;
        logic [5:0] ol;
        logic       ir;
        logic       ov;
        logic [9:0] od;
        logic [5:0] il;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] q[$];
        logic       hold, p, pp;
        logic [5:0] exp_lat;

        //           iv    id       or    ol     ir    ov    od       il
        tv[0]  = '{1'b0, 10'h000, 1'b0, 6'd0,  1'b1, 1'b0, 10'h000, 6'd0};
        tv[1]  = '{1'b0, 10'h000, 1'b0, 6'd0,  1'b1, 1'b0, 10'h000, 6'd0};
        tv[2]  = '{1'b1, 10'h011, 1'b0, 6'd5,  1'b1, 1'b0, 10'h000, 6'd0};
        tv[3]  = '{1'b1, 10'h022, 1'b0, 6'd5,  1'b1, 1'b1, 10'h011, 6'd6};
        tv[4]  = '{1'b1, 10'h033, 1'b0, 6'd5,  1'b1, 1'b1, 10'h011, 6'd7};
        tv[5]  = '{1'b0, 10'h000, 1'b0, 6'd5,  1'b1, 1'b1, 10'h011, 6'd8};
        tv[6]  = '{1'b1, 10'h044, 1'b0, 6'd5,  1'b1, 1'b1, 10'h011, 6'd8};
        tv[7]  = '{1'b1, 10'h055, 1'b0, 6'd5,  1'b0, 1'b1, 10'h011, 6'd9};
        tv[8]  = '{1'b1, 10'h055, 1'b1, 6'd5,  1'b0, 1'b1, 10'h011, 6'd9};
        tv[9]  = '{1'b1, 10'h055, 1'b0, 6'd5,  1'b1, 1'b1, 10'h022, 6'd8};
        tv[10] = '{1'b0, 10'h000, 1'b0, 6'd63, 1'b0, 1'b1, 10'h022, 6'd9};
        tv[11] = '{1'b0, 10'h000, 1'b0, 6'd60, 1'b0, 1'b1, 10'h022, 6'd63};
        tv[12] = '{1'b0, 10'h000, 1'b0, 6'd58, 1'b0, 1'b1, 10'h022, 6'd63};
        tv[13] = '{1'b0, 10'h000, 1'b1, 6'd58, 1'b0, 1'b1, 10'h022, 6'd62};
        tv[14] = '{1'b0, 10'h000, 1'b1, 6'd0,  1'b1, 1'b1, 10'h033, 6'd61};
        tv[15] = '{1'b0, 10'h000, 1'b1, 6'd0,  1'b1, 1'b1, 10'h044, 6'd2};
        tv[16] = '{1'b0, 10'h000, 1'b1, 6'd0,  1'b1, 1'b1, 10'h055, 6'd1};
        tv[17] = '{1'b0, 10'h000, 1'b0, 6'd0,  1'b1, 1'b0, 10'h000, 6'd0};

        rst_n = 1'b0;
        iv = 1'b0; id = '0; orr = 1'b0; ol = '0;
        iv3 = 1'b0; id3 = '0; or3 = 1'b0; ol3 = '0;
        #12;
        chk("reset_out_valid", 32'(ov), 32'd0);
        chk("reset_in_ready", 32'(ir), 32'd1);
        chk("reset_in_latency", 32'(il), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            iv = tv[i].iv; id = tv[i].id; orr = tv[i].orr; ol = tv[i].ol;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(ir), 32'(tv[i].ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(ov), 32'(tv[i].ov));
            chk($sformatf("vec%0d_in_latency", i), 32'(il), 32'(tv[i].il));
            if (tv[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(od), 32'(tv[i].od));
            @(posedge clk); #1;
        end

        // Streaming at constant occupancy 2 on both depths
        for (int i = 0; i < 2; i++) begin
            iv = 1'b1; id = 10'(i); orr = 1'b0; ol = '0;
            iv3 = 1'b1; id3 = 10'(i); or3 = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            iv = 1'b1; id = 10'(i + 2); orr = 1'b1;
            iv3 = 1'b1; id3 = 10'(i + 2); or3 = 1'b1;
            @(negedge clk);
            chk($sformatf("stream%0d_data", i), 32'(od), 32'(i));
            chk($sformatf("stream%0d_count", i), 32'(il), 32'd2);
            chk($sformatf("stream3_%0d_data", i), 32'(od3), 32'(i));
            chk($sformatf("stream3_%0d_count", i), 32'(il3), 32'd2);
            @(posedge clk); #1;
        end
        iv = 1'b0; iv3 = 1'b0;
        for (int i = 20; i < 22; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_data", i), 32'(od), 32'(i));
            chk($sformatf("drain3_%0d_data", i), 32'(od3), 32'(i));
            @(posedge clk); #1;
        end
        orr = 1'b0; or3 = 1'b0;
        @(negedge clk);
        chk("drained_out_valid", 32'(ov), 32'd0);
        chk("drained3_out_valid", 32'(ov3), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle with three words stored
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; id = 10'h100 + 10'(i);
            @(posedge clk); #1;
        end
        iv = 1'b0;
        @(negedge clk);
        chk("pre_reset_count", 32'(il), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(ov), 32'd0);
        chk("async_in_ready", 32'(ir), 32'd1);
        chk("async_in_latency", 32'(il), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        iv = 1'b1; id = 10'h2AA;
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 32'(ov), 32'd1);
        chk("post_reset_data", 32'(od), 32'h2AA);
        @(posedge clk); #1;
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
        @(posedge clk); #1;

        // Random backpressure soak against a scoreboard queue
        hold = 1'b0;
        exp_lat = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                iv = 1'($urandom_range(0, 1));
                id = 10'($urandom);
            end
            orr = ($urandom_range(0, 3) != 0);
            ol = 6'($urandom_range(0, 63));
            @(negedge clk);
            chk("soak_out_valid", 32'(ov), 32'(q.size() != 0));
            chk("soak_in_ready", 32'(ir), 32'(q.size() != 4));
            chk("soak_in_latency", 32'(il), 32'(exp_lat));
            if (q.size() != 0) chk("soak_out_data", 32'(od), 32'(q[0]));
            p = iv && (q.size() != 4);
            pp = orr && (q.size() != 0);
            hold = iv && !p;
            if (pp) void'(q.pop_front());
            if (p) q.push_back(id);
            exp_lat = (q.size() + int'(ol) > 63) ? 6'd63 : 6'(q.size() + int'(ol));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_fifo.md
Name: channel_fifo

Overview:
- Elastic buffer stage placed between a channel producer and a channel consumer, using the valid/ready/latency channel protocol.
- Accepts words on its input channel, stores up to DEPTH of them in order, and presents them on its output channel.
- Reports an upstream latency estimate: its own occupancy plus the latency reported by the downstream consumer, so producers can pace requests.

Parameters:
- N, 10, channel data width in bits
- LATENCY_COUNT_WIDTH, 6, width of both latency fields
- DEPTH, 4, number of storage entries; legal range 2..32, need not be a power of two

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word valid
- in_data  input  N  upstream word
- in_ready  output  1  stage can accept a word this cycle
- in_latency  output  LATENCY_COUNT_WIDTH  latency estimate reported upstream
- out_valid  output  1  head word valid
- out_data  output  N  head word
- out_ready  input  1  downstream accepts head word
- out_latency  input  LATENCY_COUNT_WIDTH  latency estimate reported by downstream

Behaviour:
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Reset (rst_n low, asynchronous): write/read pointers = 0, count = 0, out_valid = 0, in_ready = 1, in_latency = 0. out_data is don't-care while out_valid = 0. Storage contents are not reset.
- in_ready = (count != DEPTH), decoded combinationally from registered count only. It never depends on out_ready, so there is no ready combinational path through the stage.
- out_valid = (count != 0). out_data = mem[rd_ptr].
- Latency: a word pushed into an empty FIFO is visible on out_valid the next cycle. There is no fall-through.
- Order is strictly FIFO. Every accepted word is delivered exactly once; nothing is dropped or duplicated.
- Pointers increment on push/pop and wrap from DEPTH-1 to 0.
- Count width is $clog2(DEPTH+1). Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full: in_ready = 0, so no push that cycle even if a pop happens. No bypass. in_ready rises the cycle after the pop.
- Empty: out_valid = 0. A push in the same cycle is not visible at the output until the next cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance, count holds, and data order is preserved.
- out_valid/out_data must hold stable while out_valid && !out_ready.
- in_latency is registered: next = sat(count_next + out_latency) at 2^LATENCY_COUNT_WIDTH-1. The sum uses one extra bit before saturation. It reflects state one cycle late.
- Reset asserted mid-transfer: the FIFO is emptied immediately; in-flight words are discarded. The first push after deassertion is written to entry 0.
- in_valid while in_ready = 0: no state change. The upstream must hold its word under the channel rules.

Decomposition:
- Shared package channel_pkg:
  - latency saturating-add function
  - default N / LATENCY_COUNT_WIDTH constants
- One sub-module, channel_fifo_mem: DEPTH x N register array, one write port, one asynchronous read port, no reset.
- Pointers, count, flags and latency logic stay in channel_fifo.

Test Plan:
- Reset then idle, DEPTH=4: out_valid=0, in_ready=1, in_latency=0. Release rst_n with no traffic and all stay put.
- Push 0x011, 0x022, 0x033 back to back with out_ready=0:
  - out_valid rises 1 cycle after the first push; count=3, in_ready=1
  - with out_latency=5, in_latency=8
- Push 4 words with out_ready=0: in_ready=0 after the 4th. A 5th in_valid is held and not accepted. Assert out_ready for 1 cycle: 0x..1st popped, in_ready=1 next cycle, 5th word accepted afterwards; output order is intact.
- Streaming with count=2, in_valid=out_ready=1 for 20 cycles, incrementing data 0..19: count stays 2, outputs are the exact incrementing sequence, and pointers wrap cleanly (also run DEPTH=3).
- Saturation: count=4, out_latency=63 -> in_latency=63. out_latency=60 -> 63. out_latency=58 -> 62.
- Pulse rst_n low asynchronously mid-cycle with count=3: outputs immediately go to reset values. After release, push 0x2AA and observe 0x2AA first on out_data.
- Random backpressure soak, 10k cycles, against a scoreboard queue: no loss, no duplication, stable data while stalled.
